// File: rtl/regfile_write_queue_if.sv
// Bundle between the write queue, its producer and the register file ports.
// master: environment side; slave: the queue.
interface regfile_write_queue_if #(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 5,
  parameter int unsigned depth = 4,
  parameter int unsigned reads = 2
);
  localparam int unsigned CW = $clog2(depth) + 1;

  logic                   enq_valid;
  logic                   enq_ready;
  logic [n-1:0]           enq_index;
  logic [width-1:0]       enq_data;
  logic                   stall;
  logic                   wr_en;
  logic [n-1:0]           wr_index;
  logic [width-1:0]       wr_data;
  logic [reads*n-1:0]     rd_req;
  logic [reads*width-1:0] rf_resp;
  logic [reads*width-1:0] rd_resp;
  logic [CW-1:0]          count;

  modport master (
    output enq_valid, enq_index, enq_data, stall, rd_req, rf_resp,
    input  enq_ready, wr_en, wr_index, wr_data, rd_resp, count
  );

  modport slave (
    input  enq_valid, enq_index, enq_data, stall, rd_req, rf_resp,
    output enq_ready, wr_en, wr_index, wr_data, rd_resp, count
  );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order write queue in front of a single register-file write port.
// Define REGFILE_WQ_BYPASS_EN to merge pending writes into read responses.
module regfile_write_queue #(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 5,
  parameter int unsigned depth = 4,
  parameter int unsigned reads = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_queue_if.slave  bus
);
  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [n-1:0]     r_index [depth];
  logic [width-1:0] r_data  [depth];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_enq;
  logic             w_deq;

  assign bus.enq_ready = rst_n && (r_count != FULL);
  assign bus.wr_en     = rst_n && (r_count != '0) && !bus.stall;
  assign bus.wr_index  = r_index[r_head];
  assign bus.wr_data   = r_data[r_head];
  assign bus.count     = r_count;

  assign w_enq = bus.enq_valid && bus.enq_ready;
  assign w_deq = bus.wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_deq) r_head <= r_head + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload is left untouched by reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_index[r_tail] <= bus.enq_index;
      r_data[r_tail]  <= bus.enq_data;
    end
  end

`ifdef REGFILE_WQ_BYPASS_EN
  logic [depth-1:0] r_valid;

  // Enqueue never targets the draining slot: a full queue refuses enqueues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (w_deq) r_valid[r_head] <= 1'b0;
      if (w_enq) r_valid[r_tail] <= 1'b1;
    end
  end

  // Walk oldest to youngest from head so the youngest match wins.
  always_comb begin
    logic [PW-1:0] w_slot;
    w_slot      = '0;
    bus.rd_resp = bus.rf_resp;
    for (int unsigned p = 0; p < reads; p++) begin
      for (int unsigned k = 0; k < depth; k++) begin
        w_slot = r_head + PW'(k);
        if (rst_n && r_valid[w_slot] && (r_index[w_slot] == bus.rd_req[p*n +: n]))
          bus.rd_resp[p*width +: width] = r_data[w_slot];
      end
    end
  end
`else
  assign bus.rd_resp = bus.rf_resp;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue; drain order checked by a monitor,
// occupancy/handshake/bypass checked inline per scenario.
module tb_regfile_write_queue;
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

`ifdef REGFILE_WQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  wr_t  sb[$];

  regfile_write_queue_if #(.width(32), .n(5), .depth(4), .reads(2)) bus ();

  regfile_write_queue #(.width(32), .n(5), .depth(4), .reads(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Monitor: pop expected write on each drain, push on each accepted offer.
  always @(negedge clk) begin
    if (!rst_n) begin
      n_cmp++;
      if (bus.wr_en !== 1'b0) begin
        n_err++;
        $display("FAIL wr_en_in_reset: got %b want 0", bus.wr_en);
      end
      sb.delete();
    end else begin
      if (bus.wr_en === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL drain_unexpected: got idx %0d data %h want no write", bus.wr_index, bus.wr_data);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (bus.wr_index !== e.idx || bus.wr_data !== e.data) begin
            n_err++;
            $display("FAIL drain_order: got idx %0d data %h want idx %0d data %h",
                     bus.wr_index, bus.wr_data, e.idx, e.data);
          end
        end
      end
      if (bus.enq_valid === 1'b1 && bus.enq_ready === 1'b1)
        sb.push_back('{bus.enq_index, bus.enq_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] idx, input logic [31:0] d);
    bus.enq_valid = v;
    bus.enq_index = idx;
    bus.enq_data  = d;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 16; c++) begin
      if (bus.count === '0) break;
      tick();
      settle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    offer(1'b0, '0, '0);
    bus.stall   = 1'b0;
    bus.rd_req  = {5'd1, 5'd2};
    bus.rf_resp = {32'hCAFE_0002, 32'hCAFE_0001};
    repeat (2) tick();
    settle();
    n_cmp++;
    if (bus.enq_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.enq_ready); end
    n_cmp++;
    if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++;
    if (bus.rd_resp !== {32'hCAFE_0002, 32'hCAFE_0001}) begin
      n_err++; $display("FAIL reset_rd_resp: got %h want cafe0002cafe0001", bus.rd_resp);
    end
    tick();
    rst_n = 1'b1;
    settle();
    n_cmp++;
    if (bus.enq_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", bus.enq_ready); end
    n_cmp++;
    if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL post_reset_wr_en: got %b want 0", bus.wr_en); end
  endtask

  task automatic test_single_write();
    tick();
    offer(1'b1, 5'd3, 32'hA5);
    settle();
    n_cmp++;
    if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_en_early: got %b want 0", bus.wr_en); end
    tick();
    offer(1'b0, '0, '0);
    settle();
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.wr_index !== 5'd3 || bus.wr_data !== 32'hA5) begin
      n_err++;
      $display("FAIL single_drain: got en %b idx %0d data %h want en 1 idx 3 data a5",
               bus.wr_en, bus.wr_index, bus.wr_data);
    end
    n_cmp++;
    if (bus.count !== 3'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", bus.count); end
    tick();
    settle();
    n_cmp++;
    if (bus.count !== 3'd0 || bus.wr_en !== 1'b0) begin
      n_err++; $display("FAIL single_count0: got count %0d en %b want 0 0", bus.count, bus.wr_en);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.stall = 1'b1;
      offer(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      settle();
      n_cmp++;
      if (bus.count !== 3'(i) || bus.enq_ready !== (i < 4)) begin
        n_err++;
        $display("FAIL full_fill_%0d: got count %0d ready %b want count %0d ready %b",
                 i, bus.count, bus.enq_ready, i, (i < 4));
      end
      n_cmp++;
      if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL full_stall_wr_en_%0d: got %b want 0", i, bus.wr_en); end
      if (i >= 1) begin
        n_cmp++;
        if (bus.wr_index !== 5'd10 || bus.wr_data !== 32'h100) begin
          n_err++;
          $display("FAIL full_head_visible: got idx %0d data %h want idx 10 data 100", bus.wr_index, bus.wr_data);
        end
      end
    end
    tick();
    bus.stall = 1'b0;
    settle();
    n_cmp++;
    if (bus.count !== 3'd4 || bus.enq_ready !== 1'b0 || bus.wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL full_release: got count %0d ready %b en %b want 4 0 1", bus.count, bus.enq_ready, bus.wr_en);
    end
    tick();
    settle();
    n_cmp++;
    if (bus.count !== 3'd3 || bus.enq_ready !== 1'b1) begin
      n_err++; $display("FAIL full_after_drain: got count %0d ready %b want 3 1", bus.count, bus.enq_ready);
    end
    tick();
    offer(1'b0, '0, '0);
    settle();
    n_cmp++;
    if (bus.count !== 3'd3) begin n_err++; $display("FAIL full_enq_and_drain: got %0d want 3", bus.count); end
    wait_drain();
    n_cmp++;
    if (bus.count !== 3'd0 || sb.size() != 0) begin
      n_err++; $display("FAIL full_drained: got count %0d pending %0d want 0 0", bus.count, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    tick();
    bus.stall = 1'b1;
    offer(1'b1, 5'($urandom), $urandom);
    tick();
    offer(1'b1, 5'($urandom), $urandom);
    tick();
    bus.stall = 1'b0;
    offer(1'b1, 5'($urandom), $urandom);
    settle();
    n_cmp++;
    if (bus.count !== 3'd2 || bus.wr_en !== 1'b1) begin
      n_err++; $display("FAIL b2b_prime: got count %0d en %b want 2 1", bus.count, bus.wr_en);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      offer(1'b1, 5'($urandom), $urandom);
      settle();
      n_cmp++;
      if (bus.count !== 3'd2 || bus.enq_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_steady_%0d: got count %0d ready %b want 2 1", k, bus.count, bus.enq_ready);
      end
    end
    tick();
    offer(1'b0, '0, '0);
    settle();
    wait_drain();
    n_cmp++;
    if (bus.count !== 3'd0 || sb.size() != 0) begin
      n_err++; $display("FAIL b2b_drained: got count %0d pending %0d want 0 0", bus.count, sb.size());
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp0;
    bus.rd_req  = {5'd9, 5'd7};
    bus.rf_resp = {32'hDEAD_0001, 32'hF0};
    tick();
    bus.stall = 1'b1;
    offer(1'b1, 5'd7, 32'h11);
    settle();
    n_cmp++;
    if (bus.rd_resp[31:0] !== 32'hF0) begin n_err++; $display("FAIL byp_not_yet: got %h want f0", bus.rd_resp[31:0]); end
    tick();
    offer(1'b1, 5'd7, 32'h22);
    settle();
    exp0 = BYP ? 32'h11 : 32'hF0;
    n_cmp++;
    if (bus.rd_resp[31:0] !== exp0) begin n_err++; $display("FAIL byp_one: got %h want %h", bus.rd_resp[31:0], exp0); end
    tick();
    offer(1'b0, '0, '0);
    settle();
    exp0 = BYP ? 32'h22 : 32'hF0;
    n_cmp++;
    if (bus.rd_resp !== {32'hDEAD_0001, exp0}) begin
      n_err++; $display("FAIL byp_youngest: got %h want dead0001%h", bus.rd_resp, exp0);
    end
    tick();
    bus.stall = 1'b0;
    settle();
    n_cmp++;
    if (bus.rd_resp[31:0] !== exp0) begin n_err++; $display("FAIL byp_drain_old: got %h want %h", bus.rd_resp[31:0], exp0); end
    tick();
    settle();
    n_cmp++;
    if (bus.rd_resp[31:0] !== exp0 || bus.wr_en !== 1'b1) begin
      n_err++; $display("FAIL byp_drain_last: got %h en %b want %h 1", bus.rd_resp[31:0], bus.wr_en, exp0);
    end
    tick();
    settle();
    n_cmp++;
    if (bus.rd_resp[31:0] !== 32'hF0 || bus.count !== 3'd0) begin
      n_err++; $display("FAIL byp_gone: got %h count %0d want f0 0", bus.rd_resp[31:0], bus.count);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp0;
    bus.rd_req  = {5'd9, 5'd7};
    bus.rf_resp = {32'hDEAD_0001, 32'h77};
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.stall = 1'b1;
      offer(1'b1, 5'd7, 32'h55 + 32'(i));
    end
    tick();
    offer(1'b0, '0, '0);
    settle();
    exp0 = BYP ? 32'h57 : 32'h77;
    n_cmp++;
    if (bus.count !== 3'd3 || bus.rd_resp[31:0] !== exp0) begin
      n_err++; $display("FAIL mid_fill: got count %0d rd %h want 3 %h", bus.count, bus.rd_resp[31:0], exp0);
    end
    tick();
    rst_n = 1'b0;
    bus.stall = 1'b0;
    settle();
    n_cmp++;
    if (bus.enq_ready !== 1'b0 || bus.rd_resp[31:0] !== 32'h77) begin
      n_err++; $display("FAIL mid_in_reset: got ready %b rd %h want 0 77", bus.enq_ready, bus.rd_resp[31:0]);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      n_cmp++;
      if (bus.count !== 3'd0 || bus.wr_en !== 1'b0 || bus.rd_resp[31:0] !== 32'h77) begin
        n_err++;
        $display("FAIL mid_after_%0d: got count %0d en %b rd %h want 0 0 77", c, bus.count, bus.wr_en, bus.rd_resp[31:0]);
      end
      tick();
    end
  endtask

  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_index = '0;
    bus.enq_data  = '0;
    bus.stall     = 1'b0;
    bus.rd_req    = '0;
    bus.rf_resp   = '0;
    test_reset();
    test_single_write();
    test_full();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
